// File: rtl/cop_issue_queue_if.sv
// Handshake bundle between the CPU-side driver and the coprocessor issue queue.
// The master side is the CPU/coprocessor environment; the slave side is the queue.
interface cop_issue_queue_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic        instr_ready;
    logic        iss_valid;
    logic        iss_ready;
    logic [5:0]  iss_opcode;
    logic [4:0]  iss_rs1;
    logic [4:0]  iss_rs2;
    logic [4:0]  iss_rd;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        illegal;
    logic [2:0]  q_count;

    modport master (
        output instr_valid, instr, iss_ready, wb_valid, wb_rd,
        input  instr_ready, iss_valid, iss_opcode, iss_rs1, iss_rs2, iss_rd, illegal, q_count
    );

    modport slave (
        input  instr_valid, instr, iss_ready, wb_valid, wb_rd,
        output instr_ready, iss_valid, iss_opcode, iss_rs1, iss_rs2, iss_rd, illegal, q_count
    );
endinterface

// File: rtl/cop_issue_queue.sv
// Four-entry in-order coprocessor issue queue with optional register scoreboard.
// Define COP_SCOREBOARD_EN to enable RAW/WAW hazard stalls driven by the scoreboard.
module cop_issue_queue (
    input logic             clk,
    input logic             rst,
    cop_issue_queue_if.slave bus
);

    localparam logic [5:0] OP_ADD = 6'b110000;
    localparam logic [5:0] OP_SUB = 6'b110001;
    localparam logic [5:0] OP_MUL = 6'b110010;
    localparam logic [5:0] OP_DIV = 6'b110011;
    localparam logic [5:0] OP_CMP = 6'b110100;
    localparam logic [5:0] OP_REV = 6'b110101;
    localparam logic [5:0] OP_RND = 6'b110110;
    localparam logic [5:0] OP_LW  = 6'b110111;
    localparam logic [5:0] OP_SW  = 6'b111000;

    typedef struct packed {
        logic [5:0] opcode;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
    } entry_t;

    entry_t     fifo [4];
    entry_t     incoming;
    entry_t     head;
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;
    logic [2:0] count;
    logic       illegal_q;
    logic       legal;
    logic       accept;
    logic       push;
    logic       pop;
    logic       unused_instr;

    assign incoming = '{opcode: bus.instr[31:26], rs1: bus.instr[25:21],
                        rs2: bus.instr[20:16], rd: bus.instr[15:11]};
    assign unused_instr = ^bus.instr[10:0];

    assign legal  = (incoming.opcode >= OP_ADD) && (incoming.opcode <= OP_SW);
    assign accept = bus.instr_valid && bus.instr_ready;
    assign push   = accept && legal;
    assign pop    = bus.iss_valid && bus.iss_ready;
    assign head   = fifo[rd_ptr];

    assign bus.instr_ready = (count != 3'd4);
    assign bus.q_count     = count;
    assign bus.illegal     = illegal_q;
    assign bus.iss_opcode  = head.opcode;
    assign bus.iss_rs1     = head.rs1;
    assign bus.iss_rs2     = head.rs2;
    assign bus.iss_rd      = head.rd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            count     <= 3'd0;
            illegal_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
            illegal_q <= accept && !legal;
        end
    end

    // Payload storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= incoming;
    end

`ifdef COP_SCOREBOARD_EN
    logic [31:0] busy;
    logic        uses_rs1;
    logic        uses_rs2;
    logic        writes_rd;
    logic        hazard;

    always_comb begin
        uses_rs1  = 1'b0;
        uses_rs2  = 1'b0;
        writes_rd = 1'b0;
        case (head.opcode)
            OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_CMP: begin
                uses_rs1  = 1'b1;
                uses_rs2  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_REV, OP_RND: begin
                uses_rs1  = 1'b1;
                writes_rd = 1'b1;
            end
            OP_LW:   writes_rd = 1'b1;
            OP_SW:   uses_rs1  = 1'b1;
            default: ;
        endcase
    end

    assign hazard = (uses_rs1  && busy[head.rs1]) ||
                    (uses_rs2  && busy[head.rs2]) ||
                    (writes_rd && busy[head.rd]);

    assign bus.iss_valid = (count != 3'd0) && !hazard;

    // The issue-side set is written last so it wins over a same-cycle writeback clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (bus.wb_valid)      busy[bus.wb_rd] <= 1'b0;
            if (pop && writes_rd)  busy[head.rd]   <= 1'b1;
        end
    end
`else
    logic unused_wb;

    assign unused_wb     = ^{bus.wb_valid, bus.wb_rd};
    assign bus.iss_valid = (count != 3'd0);
`endif

endmodule

// File: tb/tb_cop_issue_queue.sv
// Scoreboard bench for cop_issue_queue: directed pushes queue the expected issue
// order, and a negedge monitor compares every handshake against that queue.
module tb_cop_issue_queue;

    localparam logic [5:0] OP_ADD = 6'b110000;
    localparam logic [5:0] OP_SUB = 6'b110001;
    localparam logic [5:0] OP_REV = 6'b110101;
    localparam logic [5:0] OP_LW  = 6'b110111;
    localparam logic [5:0] OP_SW  = 6'b111000;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [20:0] exp_q [$];

    cop_issue_queue_if bus ();

    cop_issue_queue dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] a,
                                       input logic [4:0] b, input logic [4:0] d);
        return {op, a, b, d, 11'd0};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drives one word for exactly one edge; the caller queues the expected issue.
    task automatic applyStimulus(input logic [31:0] w, input bit expect_issue);
        if (expect_issue) exp_q.push_back(w[31:11]);
        bus.instr_valid = 1'b1;
        bus.instr       = w;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCount(input logic [2:0] target, input int budget, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.q_count == target) begin
                hit = 1'b1;
                break;
            end
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("[TB] FAIL %s: q_count %0d never reached %0d", name, bus.q_count, target);
        end
        tick();
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rst_q_count", 32'(bus.q_count), 32'd0);
        checkOutput("rst_iss_valid", 32'(bus.iss_valid), 32'd0);
        checkOutput("rst_instr_ready", 32'(bus.instr_ready), 32'd1);
        checkOutput("rst_illegal", 32'(bus.illegal), 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_iss_valid", 32'(bus.iss_valid), 32'd0);
        checkOutput("post_rst_instr_ready", 32'(bus.instr_ready), 32'd1);
        tick();
    endtask

    // Stall window used by the hazard tests: head stays blocked until rd is written back.
    task automatic stallThenRelease(input logic [4:0] reg_id, input string name);
`ifdef COP_SCOREBOARD_EN
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput({name, "_stall"}, 32'(bus.iss_valid), 32'd0);
            tick();
        end
        bus.wb_valid = 1'b1;
        bus.wb_rd    = reg_id;
        @(negedge clk);
        checkOutput({name, "_wb_latency"}, 32'(bus.iss_valid), 32'd0);
        tick();
        bus.wb_valid = 1'b0;
        @(negedge clk);
        checkOutput({name, "_release"}, 32'(bus.iss_valid), 32'd1);
        tick();
`else
        bus.wb_rd = reg_id;
        @(negedge clk);
        checkOutput({name, "_no_stall"}, 32'(bus.iss_valid), 32'd1);
        tick();
`endif
    endtask

    always @(negedge clk) begin
        if (!rst && bus.iss_valid && bus.iss_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("[TB] FAIL issue_unexpected: got %0h with nothing expected",
                         {bus.iss_opcode, bus.iss_rs1, bus.iss_rs2, bus.iss_rd});
            end else begin
                logic [20:0] want;
                want = exp_q.pop_front();
                if ({bus.iss_opcode, bus.iss_rs1, bus.iss_rs2, bus.iss_rd} !== want) begin
                    errors++;
                    $display("[TB] FAIL issue_order: got %0h expected %0h",
                             {bus.iss_opcode, bus.iss_rs1, bus.iss_rs2, bus.iss_rd}, want);
                end
            end
        end
    end

    initial begin
        logic [5:0] bad_ops [3];
        bad_ops[0] = 6'b000111;
        bad_ops[1] = 6'b111001;
        bad_ops[2] = 6'b101111;
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.iss_ready   = 1'b0;
        bus.wb_valid    = 1'b0;
        bus.wb_rd       = '0;
        #1;
        doReset();

        $display("[TB] fill to four entries with issue blocked");
        applyStimulus(mk(OP_ADD, 5'd1, 5'd2, 5'd3), 1'b1);
        applyStimulus(mk(OP_SUB, 5'd4, 5'd5, 5'd6), 1'b1);
        applyStimulus(mk(OP_LW, 5'd0, 5'd0, 5'd10), 1'b1);
        applyStimulus(mk(OP_SW, 5'd11, 5'd0, 5'd0), 1'b1);
        @(negedge clk);
        checkOutput("full_q_count", 32'(bus.q_count), 32'd4);
        checkOutput("full_instr_ready", 32'(bus.instr_ready), 32'd0);
        checkOutput("full_iss_valid", 32'(bus.iss_valid), 32'd1);
        tick();
        applyStimulus(mk(OP_ADD, 5'd7, 5'd8, 5'd9), 1'b0);
        @(negedge clk);
        checkOutput("fifth_rejected", 32'(bus.q_count), 32'd4);
        tick();
        bus.iss_ready = 1'b1;
        waitCount(3'd0, 12, "drain_full");

        $display("[TB] illegal opcodes");
        bus.iss_ready = 1'b0;
        applyStimulus(mk(OP_SW, 5'd13, 5'd0, 5'd0), 1'b1);
        for (int k = 0; k < 3; k++) begin
            bus.instr_valid = 1'b1;
            bus.instr       = mk(bad_ops[k], 5'd1, 5'd2, 5'd3);
            @(negedge clk);
            checkOutput("illegal_early", 32'(bus.illegal), 32'd0);
            tick();
            bus.instr_valid = 1'b0;
            @(negedge clk);
            checkOutput("illegal_pulse", 32'(bus.illegal), 32'd1);
            checkOutput("illegal_not_queued", 32'(bus.q_count), 32'd1);
            tick();
            @(negedge clk);
            checkOutput("illegal_width", 32'(bus.illegal), 32'd0);
            tick();
        end
        bus.iss_ready = 1'b1;
        waitCount(3'd0, 8, "drain_illegal");

        $display("[TB] read-after-write hazard on r5");
        doReset();
        applyStimulus(mk(OP_ADD, 5'd1, 5'd2, 5'd5), 1'b1);
        applyStimulus(mk(OP_SUB, 5'd5, 5'd6, 5'd8), 1'b1);
        stallThenRelease(5'd5, "raw");
        waitCount(3'd0, 8, "drain_raw");

        $display("[TB] streaming push/pop across pointer wrap");
        doReset();
        bus.iss_ready = 1'b0;
        applyStimulus(mk(OP_SW, 5'd1, 5'd2, 5'd3), 1'b1);
        applyStimulus(mk(OP_SW, 5'd2, 5'd3, 5'd4), 1'b1);
        @(negedge clk);
        checkOutput("stream_start_count", 32'(bus.q_count), 32'd2);
        tick();
        bus.iss_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bus.instr_valid = 1'b1;
            bus.instr       = mk(OP_SW, 5'(10 + k), 5'(20 + k), 5'(k));
            exp_q.push_back(bus.instr[31:11]);
            @(negedge clk);
            checkOutput("stream_count", 32'(bus.q_count), 32'd2);
            tick();
        end
        bus.instr_valid = 1'b0;
        @(negedge clk);
        checkOutput("stream_end_count", 32'(bus.q_count), 32'd2);
        tick();
        waitCount(3'd0, 8, "drain_stream");

        $display("[TB] asynchronous reset with entries queued and r7 busy");
        applyStimulus(mk(OP_ADD, 5'd1, 5'd2, 5'd7), 1'b1);
        waitCount(3'd0, 8, "issue_add_r7");
        bus.iss_ready = 1'b0;
        applyStimulus(mk(OP_LW, 5'd0, 5'd0, 5'd7), 1'b0);
        applyStimulus(mk(OP_SW, 5'd20, 5'd21, 5'd22), 1'b0);
        applyStimulus(mk(OP_SW, 5'd23, 5'd24, 5'd25), 1'b0);
        @(negedge clk);
        checkOutput("pre_rst_count", 32'(bus.q_count), 32'd3);
`ifdef COP_SCOREBOARD_EN
        checkOutput("pre_rst_waw_stall", 32'(bus.iss_valid), 32'd0);
`else
        checkOutput("pre_rst_iss_valid", 32'(bus.iss_valid), 32'd1);
`endif
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_rst_count", 32'(bus.q_count), 32'd0);
        checkOutput("async_rst_iss_valid", 32'(bus.iss_valid), 32'd0);
        checkOutput("async_rst_instr_ready", 32'(bus.instr_ready), 32'd1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("release_iss_valid", 32'(bus.iss_valid), 32'd0);
        tick();
        bus.iss_ready = 1'b1;
        applyStimulus(mk(OP_LW, 5'd0, 5'd0, 5'd7), 1'b1);
        @(negedge clk);
        checkOutput("lw_r7_after_rst", 32'(bus.iss_valid), 32'd1);
        tick();

        $display("[TB] issue and writeback of r9 in the same cycle");
        applyStimulus(mk(OP_LW, 5'd0, 5'd0, 5'd9), 1'b1);
        bus.wb_valid = 1'b1;
        bus.wb_rd    = 5'd9;
        applyStimulus(mk(OP_REV, 5'd9, 5'd0, 5'd12), 1'b1);
        bus.wb_valid = 1'b0;
        stallThenRelease(5'd9, "set_wins");
        waitCount(3'd0, 8, "drain_set_wins");

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        checkOutput("expected_all_issued", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cop_issue_queue.md
COP_ISSUE_QUEUE -- requirements
Module: cop_issue_queue

Interface
REQ-001 SHALL have ports, clock and reset first (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- instr_valid  in  1  CPU presents a coprocessor instruction word.
- instr  in  32  instruction: [31:26] opcode, [25:21] rs1, [20:16] rs2, [15:11] rd.
- instr_ready  out  1  queue can accept a word this cycle.
- iss_valid  out  1  head instruction is issuable to the coprocessor.
- iss_ready  in  1  coprocessor accepts the head instruction.
- iss_opcode  out  6  head opcode.
- iss_rs1, iss_rs2, iss_rd  out  5 each  head register addresses.
- wb_valid  in  1  coprocessor finished a register write.
- wb_rd  in  5  register written.
- illegal  out  1  one-cycle pulse: a non-coprocessor opcode was accepted.
- q_count  out  3  current queue occupancy, 0..4.

Function
REQ-002 SHALL buffer instructions in a 4-entry FIFO with 2-bit read and write pointers that wrap from 3 to 0.
REQ-003 SHALL assert instr_ready = (q_count != 4), registered-state based, independent of iss_ready.
REQ-004 SHALL complete a push on instr_valid & instr_ready.
REQ-005 SHALL treat opcodes 110000 to 111000 as legal: add, sub, mul, div, cmp, rev, rnd, lw, sw.
REQ-006 SHALL handle an accepted illegal opcode as follows: not enqueued; illegal = 1 on the following cycle for exactly one cycle.
REQ-007 SHALL drive iss_opcode, iss_rs1, iss_rs2 and iss_rd combinationally from the FIFO head entry.
REQ-008 SHALL apply these operand-use rules:
- add, sub, mul, div, cmp: read rs1 and rs2, write rd.
- rev, rnd: read rs1, write rd.
- lw: writes rd only.
- sw: reads rs1 only.
REQ-009 SHALL assert iss_valid = (q_count != 0) & !hazard.
REQ-010 SHALL define hazard as any used source register, or the written rd (WAW), having its scoreboard bit set.
REQ-011 SHALL pop the head on iss_valid & iss_ready; if the instruction writes rd, SHALL set scoreboard bit rd at that edge.
REQ-012 SHALL clear scoreboard bit wb_rd on wb_valid; a clear is visible to the hazard check from the next cycle.
REQ-013 SHALL, when an issue sets and wb_valid clears the same register in one cycle, leave the bit set (set wins).
REQ-014 SHALL, on a simultaneous push and pop, leave q_count unchanged; when q_count = 1, a new entry becomes head only on the cycle after the pop.
REQ-015 SHALL, once iss_valid rises, hold it and the iss_* fields stable until the handshake, because only an issue can set scoreboard bits.
REQ-016 SHALL ignore wb_valid for a register whose bit is already clear.

Reset
REQ-017 SHALL, while rst = 1 (asynchronously, any cycle including mid-handshake), clear the pointers, q_count and all 32 scoreboard bits, and force illegal = 0; queued entries are discarded.
REQ-018 SHALL hold iss_valid = 0 and instr_ready = 1 during reset and in the first cycle after release.

Configuration
REQ-019 SHALL gate hazard logic with macro COP_SCOREBOARD_EN:
- Defined: scoreboard and hazard logic per REQ-010 to REQ-013.
- Undefined: no scoreboard storage, iss_valid = (q_count != 0), wb_valid and wb_rd ignored.

Verification
REQ-020 Bench SHALL push four legal instructions while iss_ready = 0 -> q_count = 4, instr_ready = 0, a fifth word is not accepted.
REQ-021 Bench SHALL push opcode 000111 -> not enqueued, q_count unchanged, illegal high exactly one cycle.
REQ-022 Bench SHALL issue add rd=5, then push sub rs1=5 -> iss_valid = 0 until wb_valid with wb_rd = 5; iss_valid = 1 the cycle after (scoreboard build only).
REQ-023 Bench SHALL, with iss_ready = 1 and q_count = 2, push and pop together -> q_count stays 2 and FIFO order is preserved across the pointer wrap 3 -> 0.
REQ-024 Bench SHALL assert rst with 3 entries queued and scoreboard bit 7 set -> q_count = 0, iss_valid = 0, bit 7 clear; then lw rd=7 issues immediately.
REQ-025 Bench SHALL issue lw rd=9 while wb_valid, wb_rd = 9 in the same cycle -> bit 9 remains set, and a following rev rs1=9 stalls.
